// File: rtl/srff_if.sv
// rtl/srff_if.sv - set/clear request and complementary state bundle for srff
interface srff_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;

  modport master (output s, output r, input q, input qb);
  modport slave  (input s, input r, output q, output qb);
endinterface

// File: rtl/srff.sv
// rtl/srff.sv - bit-parallel synchronous SR flip-flop with complementary outputs
// Optional SRFF_CHECK_EN compiles in simulation-only checks on s=r=1 and q/qb.
module srff #(
  parameter int               WIDTH        = 1,
  parameter logic [WIDTH-1:0] RST_VAL      = '0,
  parameter int               INVALID_MODE = 0
) (
  input  logic  clk,
  input  logic  rst,
  srff_if.slave bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;

  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({bus.s[i], bus.r[i]})
        2'b10:   w_q_nxt[i] = 1'b1;
        2'b01:   w_q_nxt[i] = 1'b0;
        2'b11: begin
          // out-of-range modes fall back to hold
          case (INVALID_MODE)
            1:       w_q_nxt[i] = 1'b0;
            2:       w_q_nxt[i] = 1'b1;
            3:       w_q_nxt[i] = ~r_q[i];
            default: w_q_nxt[i] = r_q[i];
          endcase
        end
        default: w_q_nxt[i] = r_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_q <= RST_VAL;
    else     r_q <= w_q_nxt;
  end

  // qb is derived, never stored, so it cannot disagree with q
  assign bus.q  = r_q;
  assign bus.qb = ~r_q;

`ifdef SRFF_CHECK_EN
  logic r_rst_seen;

  always_ff @(posedge clk) begin
    if (rst) r_rst_seen <= 1'b1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.s[i] && bus.r[i])
          $warning("srff: s=r=1 at time %0t on bit %0d", $time, i);
      end
    end
    if (r_rst_seen === 1'b1 && bus.qb !== ~bus.q)
      $error("srff: qb=%b is not the inverse of q=%b at time %0t", bus.qb, bus.q, $time);
  end
`else
  // checks compiled out
`endif

endmodule

// File: tb/tb_srff.sv
// tb/tb_srff.sv - scoreboard bench for srff across all forbidden-input modes
module tb_srff;
  logic       clk = 1'b0;
  logic       rst_v = 1'b0;
  logic [1:0] s_v = 2'b00;
  logic [1:0] r_v = 2'b00;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic [1:0] q0;
    logic       q1;
    logic       q2;
    logic       q3;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m0 = 2'bxx;
  logic       m1 = 1'bx;
  logic       m2 = 1'bx;
  logic       m3 = 1'bx;

  always #5 clk = ~clk;

  srff_if #(.WIDTH(2)) if0 ();
  srff_if #(.WIDTH(1)) if1 ();
  srff_if #(.WIDTH(1)) if2 ();
  srff_if #(.WIDTH(1)) if3 ();

  assign if0.s = s_v;
  assign if0.r = r_v;
  assign if1.s = s_v[0];
  assign if1.r = r_v[0];
  assign if2.s = s_v[0];
  assign if2.r = r_v[0];
  assign if3.s = s_v[0];
  assign if3.r = r_v[0];

  srff #(.WIDTH(2), .RST_VAL(2'b00), .INVALID_MODE(0)) u0 (.clk(clk), .rst(rst_v), .bus(if0));
  srff #(.WIDTH(1), .RST_VAL(1'b1),  .INVALID_MODE(1)) u1 (.clk(clk), .rst(rst_v), .bus(if1));
  srff #(.WIDTH(1), .RST_VAL(1'b0),  .INVALID_MODE(2)) u2 (.clk(clk), .rst(rst_v), .bus(if2));
  srff #(.WIDTH(1), .RST_VAL(1'b0),  .INVALID_MODE(3)) u3 (.clk(clk), .rst(rst_v), .bus(if3));

  function automatic logic mbit(logic q, logic s, logic r, logic rst, logic rv, int mode);
    if (rst)       return rv;
    if (s && !r)   return 1'b1;
    if (!s && r)   return 1'b0;
    if (!s && !r)  return q;
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~q;
      default: return q;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    m0[0] = mbit(m0[0], s_v[0], r_v[0], rst_v, 1'b0, 0);
    m0[1] = mbit(m0[1], s_v[1], r_v[1], rst_v, 1'b0, 0);
    m1    = mbit(m1, s_v[0], r_v[0], rst_v, 1'b1, 1);
    m2    = mbit(m2, s_v[0], r_v[0], rst_v, 1'b0, 2);
    m3    = mbit(m3, s_v[0], r_v[0], rst_v, 1'b0, 3);
    e.q0 = m0; e.q1 = m1; e.q2 = m2; e.q3 = m3;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk({tag, ".q0"},  if0.q,  e.q0);
    chk({tag, ".qb0"}, if0.qb, ~e.q0);
    chk({tag, ".q1"},  {1'b0, if1.q},  {1'b0, e.q1});
    chk({tag, ".qb1"}, {1'b0, if1.qb}, {1'b0, ~e.q1});
    chk({tag, ".q2"},  {1'b0, if2.q},  {1'b0, e.q2});
    chk({tag, ".qb2"}, {1'b0, if2.qb}, {1'b0, ~e.q2});
    chk({tag, ".q3"},  {1'b0, if3.q},  {1'b0, e.q3});
    chk({tag, ".qb3"}, {1'b0, if3.qb}, {1'b0, ~e.q3});
  endtask

  task automatic drive(input logic rst, input logic [1:0] s, input logic [1:0] r);
    @(negedge clk);
    rst_v = rst;
    s_v   = s;
    r_v   = r;
  endtask

  initial begin
    // reset held 3 edges while set is requested
    drive(1'b1, 2'b01, 2'b00);
    repeat (3) begin
      tick("rst_hold");
      chk("rst_q0_const", if0.q, 2'b00);
      chk("rst_q1_const", {1'b0, if1.q}, 2'b01);
    end
    drive(1'b0, 2'b00, 2'b00); tick("rst_release");
    chk("release_q0_const", if0.q, 2'b00);

    drive(1'b0, 2'b01, 2'b00); tick("set");
    chk("set_q0_const", if0.q, 2'b01);
    drive(1'b0, 2'b00, 2'b00); tick("hold_a"); tick("hold_b");
    chk("hold_q0_const", if0.q, 2'b01);
    drive(1'b0, 2'b00, 2'b01); tick("clear");
    chk("clear_qb0_const", if0.qb, 2'b11);

    drive(1'b0, 2'b10, 2'b00); tick("bit1_only");
    chk("bit1_only_const", if0.q, 2'b10);
    drive(1'b0, 2'b01, 2'b00); tick("set_both");
    drive(1'b0, 2'b01, 2'b01); tick("sr11_from1");
    chk("sr11_hold1_const", if0.q, 2'b11);
    chk("sr11_mode1_const", {1'b0, if1.q}, 2'b00);
    chk("sr11_mode2_const", {1'b0, if2.q}, 2'b01);
    drive(1'b0, 2'b00, 2'b01); tick("clear_bit0");

    drive(1'b0, 2'b01, 2'b01);
    tick("tog1"); chk("tog1_const", {1'b0, if3.q}, 2'b01);
    tick("tog2"); chk("tog2_const", {1'b0, if3.q}, 2'b00);
    tick("tog3"); chk("tog3_const", {1'b0, if3.q}, 2'b01);
    tick("tog4"); chk("tog4_const", {1'b0, if3.q}, 2'b00);
    chk("sr11_hold0_const", if0.q, 2'b10);

    drive(1'b0, 2'b01, 2'b00); tick("set_again");
    drive(1'b1, 2'b01, 2'b00); tick("rst_priority");
    chk("rst_priority_const", if0.q, 2'b00);
    drive(1'b0, 2'b00, 2'b00); tick("idle");

    // free-running overlapped stimulus, offset away from clock edges
    s_v = 2'b00; r_v = 2'b00; rst_v = 1'b0;
    fork
      begin #5 rst_v = 1'b1; #30 rst_v = 1'b0; end
      begin repeat (4) begin #30 s_v = ~s_v; end end
      begin repeat (3) begin #40 r_v = ~r_v; end end
    join_none
    repeat (12) tick("free");
    #5;

    chk("sb_empty", {1'b0, (sb.size() == 0)}, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
